// File: rtl/mem_arbiter.sv
// mem_arbiter: multicycle arbiter that shares one memory between the
// instruction-fetch (IF) port and the data-memory (DM) port of the CPU.
// One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP.
// Unaligned addresses skip ACCESS and answer with rsp_err in RESP.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between
// simultaneous requesters; otherwise DM has fixed priority over IF.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_req, if_addr     IF read request (held until if_ready)
//   dm_req, dm_we,
//   dm_addr, dm_wdata   DM read/write request (held until dm_ready)
//   if_ready, dm_ready  one-cycle completion pulses
//   rsp_rdata, rsp_err  response data / unaligned flag, valid with a ready
//   busy                high whenever not IDLE
//   mem_addr, mem_wdata,
//   mem_read, mem_write to the memory
//   mem_rdata           from the memory (combinational read)
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        if_ready,
  output logic        dm_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | waiting for a request; winner is latched at the edge
  // ACCESS | memory driven; counter runs down to 0 (last cycle)
  // RESP   | owner's ready pulse, rsp_rdata/rsp_err valid
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        owner_dm;
  logic        we_q;

  logic        grant_dm;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;

`ifdef MEM_ARB_RR_EN
  // 1 = DM won the previous arbitration; reset value means "IF last".
  logic last_dm;

  always_comb begin
    grant_dm = dm_req && (!if_req || !last_dm);
  end
`else
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  always_comb begin
    sel_addr  = grant_dm ? dm_addr : if_addr;
    sel_wdata = grant_dm ? dm_wdata : 32'h0;
    sel_we    = grant_dm & dm_we;
  end

  // Decoded rather than registered so that it drops the instant rst_n falls
  // and can never stay high into RESP.
  assign mem_write = rst_n && (state == ACCESS) && (cnt == 4'd0) && we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_dm  <= 1'b0;
      we_q      <= 1'b0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_read  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dm   <= 1'b0;
`endif
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner_dm  <= grant_dm;
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            busy      <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_dm   <= grant_dm;
`endif
            if (sel_addr[1:0] == 2'b00) begin
              state    <= ACCESS;
              cnt      <= WAIT_LD;
              mem_read <= !sel_we;
              rsp_err  <= 1'b0;
            end else begin
              // Unaligned: answer straight away, memory untouched.
              state     <= RESP;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
              if_ready  <= !grant_dm;
              dm_ready  <= grant_dm;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= we_q ? 32'h0 : mem_rdata;
            mem_read  <= 1'b0;
            state     <= RESP;
            if_ready  <= !owner_dm;
            dm_ready  <= owner_dm;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int W1 = 1;
  localparam int W0 = 0;

  logic        clk;
  logic        rst_n;
  logic        mem_init;
  logic        if_req, dm_req, if_req0, dm_req0;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        dm_we;

  logic        if_ready, dm_ready, rsp_err, busy, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready0, dm_ready0, rsp_err0, busy0, mem_read0, mem_write0;
  logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;

  logic [31:0] mem1 [64];
  logic [31:0] mem0 [64];
  logic [31:0] ref_mem [64];

  int nvec = 0;
  int nmis = 0;

  mem_arbiter #(.WAIT_CYCLES(W1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_ready(if_ready), .dm_ready(dm_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req0), .if_addr(if_addr),
    .dm_req(dm_req0), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_ready(if_ready0), .dm_ready(dm_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_rdata(mem_rdata0)
  );

  function automatic logic [31:0] pat(int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
  endfunction

  // Memories attached to the two arbiters: combinational read, write on edge.
  assign mem_rdata  = mem1[mem_addr[7:2]];
  assign mem_rdata0 = mem0[mem_addr0[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= pat(i);
        mem0[i] <= pat(i);
      end
    end else begin
      if (mem_write)  mem1[mem_addr[7:2]]  <= mem_wdata;
      if (mem_write0) mem0[mem_addr0[7:2]] <= mem_wdata0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request on one port, held until its ready (bounded), then released.
  task automatic run_txn(input bit use0, input bit is_dm, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err,
                         input int exp_lat, input string nm);
    int n, nwr;
    bit seen, other, rdy, oth, wr;
    logic [31:0] rd;
    logic er;
    dm_we = we; dm_addr = addr; dm_wdata = wdata; if_addr = addr;
    if (use0) begin
      if (is_dm) dm_req0 = 1'b1; else if_req0 = 1'b1;
    end else begin
      if (is_dm) dm_req = 1'b1; else if_req = 1'b1;
    end
    n = 0; nwr = 0; seen = 0; other = 0; rd = 32'h0; er = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      rdy = use0 ? (is_dm ? dm_ready0 : if_ready0) : (is_dm ? dm_ready : if_ready);
      oth = use0 ? (is_dm ? if_ready0 : dm_ready0) : (is_dm ? if_ready : dm_ready);
      wr  = use0 ? mem_write0 : mem_write;
      if (wr) nwr++;
      if (oth) other = 1;
      if (rdy) begin
        seen = 1;
        rd = use0 ? rsp_rdata0 : rsp_rdata;
        er = use0 ? rsp_err0 : rsp_err;
      end
    end
    if_req = 0; dm_req = 0; if_req0 = 0; dm_req0 = 0;
    chk({nm, " ready seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, 32'(er), 32'(exp_err));
    chk({nm, " write pulses"}, nwr, (is_dm && we && !exp_err) ? 1 : 0);
    chk({nm, " other ready"}, 32'(other), 32'd0);
    if (!use0 && is_dm && we && !exp_err) ref_mem[addr[7:2]] = wdata;
    @(negedge clk);
    chk({nm, " busy after"}, 32'(use0 ? busy0 : busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {24'h0, 6'($urandom % 64), 2'b00};
    if ($urandom % 8 == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int t, ngr, ng;
    bit gd [4];
    int gt [4];
    // random-phase model state
    int e, r, next_acc;
    bit pend, m_dm, m_we, m_err, m_last;
    logic [31:0] m_addr, m_exp;
    bit x_if, x_dm, x_busy, x_rd, x_wr, both;

    tbl[0] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0};
    tbl[1] = '{1, 1, 32'h20, 32'h12345678, 32'h0,        0};
    tbl[2] = '{0, 0, 32'h20, 32'h0,        32'h12345678, 0};
    tbl[3] = '{1, 1, 32'h22, 32'hAAAA5555, 32'h0,        1};
    tbl[4] = '{1, 0, 32'h20, 32'h0,        32'h12345678, 0};
    tbl[5] = '{0, 0, 32'h06, 32'h0,        32'h0,        1};
    tbl[6] = '{1, 1, 32'h3C, 32'hCAFEF00D, 32'h0,        0};
    tbl[7] = '{0, 0, 32'h3C, 32'h0,        32'hCAFEF00D, 0};
    tbl[8] = '{1, 0, 32'h00, 32'h0,        32'h10000000, 0};
    tbl[9] = '{1, 0, 32'h01, 32'h0,        32'h0,        1};

    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    rst_n = 0; mem_init = 1;
    if_req = 0; dm_req = 0; if_req0 = 0; dm_req0 = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_we = 0;
    repeat (2) @(negedge clk);
    mem_init = 0;

    // reset state
    chk("reset ctrl", {26'h0, if_ready, dm_ready, busy, mem_read, mem_write, rsp_err}, 32'h0);
    chk("reset rdata", rsp_rdata, 32'h0);
    chk("reset addr", mem_addr, 32'h0);
    chk("reset wdata", mem_wdata, 32'h0);
    chk("reset ctrl w0", {26'h0, if_ready0, dm_ready0, busy0, mem_read0, mem_write0, rsp_err0}, 32'h0);
    rst_n = 1;
    @(negedge clk);

    // directed table on the WAIT_CYCLES=1 arbiter
    for (int i = 0; i < 10; i++) begin
      run_txn(0, tbl[i].dm, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd,
              tbl[i].exp_err, tbl[i].exp_err ? 1 : W1 + 2, $sformatf("vec%0d", i));
    end
    chk("unaligned write left word", mem1[8], 32'h12345678);

    // simultaneous requests
`ifdef MEM_ARB_RR_EN
    ng = 4;
`else
    ng = 2;
`endif
    if_addr = 32'h4; dm_addr = 32'h8; dm_we = 0; if_req = 1; dm_req = 1;
    t = 0; ngr = 0;
    while (ngr < ng && t < 40) begin
      @(negedge clk);
      t++;
      if (dm_ready) begin
        gd[ngr] = 1; gt[ngr] = t; ngr++;
        chk("tie dm rdata", rsp_rdata, ref_mem[2]);
`ifndef MEM_ARB_RR_EN
        dm_req = 0;
`endif
      end else if (if_ready) begin
        gd[ngr] = 0; gt[ngr] = t; ngr++;
        chk("tie if rdata", rsp_rdata, ref_mem[1]);
      end
    end
    if_req = 0; dm_req = 0;
    chk("tie grants", ngr, ng);
    for (int i = 0; i < ngr; i++) begin
      chk($sformatf("tie grant%0d owner", i), 32'(gd[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tie grant%0d time", i), gt[i], (W1 + 2) + i * (W1 + 3));
    end
    @(negedge clk);

    // reset during the second ACCESS cycle of a write
    dm_we = 1; dm_addr = 32'h30; dm_wdata = 32'hBADC0DE0; dm_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("abort mem_write before reset", 32'(mem_write), 32'd1);
    rst_n = 0;
    #1;
    chk("abort mem_write", 32'(mem_write), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", {30'h0, if_ready, dm_ready}, 32'd0);
    dm_req = 0;
    @(negedge clk);
    chk("abort word unchanged", mem1[12], ref_mem[12]);
    rst_n = 1;
    @(negedge clk);
    run_txn(0, 1, 0, 32'h30, 32'h0, ref_mem[12], 0, W1 + 2, "post-reset read");

    // WAIT_CYCLES=0 arbiter
    run_txn(1, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, W0 + 2, "w0 if read");
    if_addr = 32'h14; if_req0 = 1; t = 0; ngr = 0;
    while (ngr < 3 && t < 30) begin
      @(negedge clk);
      t++;
      if (if_ready0) begin
        chk($sformatf("w0 b2b%0d rdata", ngr), rsp_rdata0, pat(5));
        chk($sformatf("w0 b2b%0d time", ngr), t, 2 + 3 * ngr);
        ngr++;
      end
    end
    if_req0 = 0;
    chk("w0 b2b count", ngr, 3);
    @(negedge clk);

    // randomized traffic against a transaction-level model
    e = 0; r = 0; next_acc = 0; pend = 0;
    m_dm = 0; m_we = 0; m_err = 0; m_addr = 0; m_exp = 0;
    m_last = 1;  // last grant above went to DM
    for (int it = 0; it < 3000; it++) begin
      x_if   = pend && !m_dm && e == r;
      x_dm   = pend && m_dm && e == r;
      x_busy = pend && e <= r;
      x_rd   = pend && !m_err && !m_we && e < r;
      x_wr   = pend && !m_err && m_we && e == r - 1;
      chk("rnd if_ready", 32'(if_ready), 32'(x_if));
      chk("rnd dm_ready", 32'(dm_ready), 32'(x_dm));
      chk("rnd busy", 32'(busy), 32'(x_busy));
      chk("rnd mem_read", 32'(mem_read), 32'(x_rd));
      chk("rnd mem_write", 32'(mem_write), 32'(x_wr));
      if (pend && e == r) begin
        chk("rnd rdata", rsp_rdata, m_exp);
        chk("rnd err", 32'(rsp_err), 32'(m_err));
      end
      if (pend && !m_err && e < r) chk("rnd mem_addr", mem_addr, m_addr);

      // requester behaviour
      if (pend && e == r) begin
        if (m_dm) begin
          if ($urandom % 2 == 0) dm_req = 0;
          else begin dm_we = 1'($urandom); dm_addr = rand_addr(); dm_wdata = $urandom; end
        end else begin
          if ($urandom % 2 == 0) if_req = 0;
          else if_addr = rand_addr();
        end
      end
      if (pend && e < r && $urandom % 4 == 0) begin
        if (m_dm) begin dm_we = 1'($urandom); dm_addr = rand_addr(); dm_wdata = $urandom; end
        else if_addr = rand_addr();
      end
      if (!dm_req && $urandom % 10 < 3) begin
        dm_req = 1; dm_we = 1'($urandom); dm_addr = rand_addr(); dm_wdata = $urandom;
      end
      if (!if_req && $urandom % 10 < 3) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (pend && e >= r) pend = 0;

      // arbitration at the coming edge
      if (!pend && e + 1 >= next_acc && (if_req || dm_req)) begin
        both = if_req && dm_req;
`ifdef MEM_ARB_RR_EN
        m_dm = both ? !m_last : dm_req;
`else
        m_dm = dm_req;
`endif
        m_last = m_dm;
        m_addr = m_dm ? dm_addr : if_addr;
        m_we   = m_dm && dm_we;
        m_err  = (m_addr % 4) != 0;
        m_exp  = (m_err || m_we) ? 32'h0 : ref_mem[m_addr[7:2]];
        if (!m_err && m_we) ref_mem[m_addr[7:2]] = dm_wdata;
        r = m_err ? e + 1 : e + 1 + W1 + 1;
        next_acc = r + 2;
        pend = 1;
      end
      @(negedge clk);
      e++;
    end
    if_req = 0; dm_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multicycle arbiter that shares the single `mem` instance between the instruction-fetch port (IF) and the data-memory port (DM) of the CPU. It accepts one request at a time and drives the memory's address, data and read/write controls. It inserts a configurable number of wait states and returns read data with a one-cycle ready pulse, so the datapath stalls until its access completes. It sits between `yIF`/`yDM` and `mem`, replacing their private memory connections.

## Interface
- WAIT_CYCLES, 1: extra ACCESS cycles per transaction (legal 0..15).
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF requests a read; held until if_ready.
- if_addr  in  32  IF byte address.
- dm_req  in  1  DM requests an access; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  DM byte address.
- dm_wdata  in  32  DM write data.
- if_ready  out  1  one-cycle pulse: IF transaction complete.
- dm_ready  out  1  one-cycle pulse: DM transaction complete.
- rsp_rdata  out  32  read data; valid only while a ready pulse is high.
- rsp_err  out  1  unaligned address; valid only while a ready pulse is high.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  32  to `mem` address.
- mem_wdata  out  32  to `mem` memIn.
- mem_read  out  1  to `mem` read.
- mem_write  out  1  to `mem` write.
- mem_rdata  in  32  from `mem` memOut; combinational read.

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - At the clock edge, if any request is high: pick the winner, and latch owner, addr, we and wdata (IF always has we=0).
  - Aligned address (addr[1:0]==0): go to ACCESS and load wait counter = WAIT_CYCLES.
  - Unaligned address: go directly to RESP with err=1 and rdata=0. No memory access occurs.
- **ACCESS**
  - Drive mem_addr and mem_wdata from the latched values. mem_read = !we.
  - Counter > 0: decrement it.
  - Counter == 0 (last ACCESS cycle): capture mem_rdata into rsp_rdata (reads only), assert mem_write=we for this single cycle, and go to RESP.
- **RESP**
  - Pulse the owner's ready for exactly one cycle. rsp_err holds the latched error flag.
  - Go to IDLE.
- Writes: rsp_rdata is 0 in the response cycle.
- Arbitration is fixed priority: DM beats IF, so the in-flight instruction's load/store completes before the next fetch.
- A request that stays high after its ready pulse is sampled in IDLE as a new transaction.
- Changing addr, we or wdata after acceptance has no effect on the transaction.
- Request inputs are ignored outside IDLE. A losing requester waits with its req held.

## Timing
- Reset (asynchronous): state=IDLE; if_ready, dm_ready, rsp_err, busy, mem_read, mem_write = 0; rsp_rdata, mem_addr, mem_wdata = 0.
- Reset asserted mid-transaction aborts it. mem_write falls combinationally with rst_n, so no partial write occurs.
- Latency: request sampled at edge E0 → ACCESS occupies WAIT_CYCLES+1 cycles → ready high in the cycle after them. The ready pulse is the (WAIT_CYCLES+2)th cycle after E0.
- Unaligned request: ready high in the first cycle after E0.
- Throughput: one transaction per WAIT_CYCLES+3 cycles (including the IDLE cycle).
- mem_write is high for exactly one cycle per write transaction. It is never high in IDLE or RESP.
- mem_read is 0 in IDLE and RESP.
- Outputs are registered, except mem_write, which is decoded from state, counter and the latched we, gated by rst_n.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A one-bit pointer records the last winner.
  - On a simultaneous request, the port that did not win last time wins.
  - The pointer resets to "IF last", so DM wins the first tie.
  - With a single requester, that requester always wins.
- MEM_ARB_RR_EN undefined: fixed priority, DM over IF. Under continuous dm_req, IF starvation is permitted.

## Test plan
- Single IF read, WAIT_CYCLES=1, arr[0x10]=0xDEADBEEF, if_req with if_addr=0x10 → ACCESS for 2 cycles, if_ready pulse one cycle, rsp_rdata=0xDEADBEEF, rsp_err=0, dm_ready stays 0.
- DM write then IF read of the same address: dm_we=1, dm_addr=0x20, dm_wdata=0x12345678 → mem_write high exactly one cycle, dm_ready pulse; then IF read of 0x20 → rsp_rdata=0x12345678.
- Simultaneous if_req and dm_req (read 0x4, 0x8), fixed priority → dm_ready first, then if_ready WAIT_CYCLES+3 cycles later. With MEM_ARB_RR_EN and both held high → grants alternate DM, IF, DM, IF.
- Unaligned dm_addr=0x22 with dm_we=1 → dm_ready on the cycle after acceptance, rsp_err=1, rsp_rdata=0, mem_write never asserted, memory contents unchanged.
- rst_n pulled low during the second ACCESS cycle of a write → mem_write, busy and ready drop immediately, target word unchanged. After release, state is IDLE and a fresh request completes normally.
- WAIT_CYCLES=0, IF read → if_ready exactly two cycles after the accepting edge; back-to-back held if_req yields one ready pulse every 3 cycles.
